// File: rtl/if_bht_fetch.sv
// Instruction-fetch stage: direct-mapped i-cache, 2-bit BHT direction
// prediction and static JAL redirect, feeding one instruction per cycle
// to issue.
module if_bht_fetch #(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 6,
  parameter int ADDR_W       = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic [31:0] jump_pc,
  input  logic        RS_full,
  input  logic        SLB_full,
  input  logic        ROB_full,
  output logic        ID_send,
  output logic [31:0] instruction,
  output logic        pred_result,
  output logic [31:0] inst_pc,
  input  logic        mem_valid,
  input  logic [31:0] mem_val,
  output logic        mem_send,
  output logic [31:0] mem_addr,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;
  localparam int IC_N  = 1 << ICACHE_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {IDLE, MISS} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_send_q, id_send_d;
  logic [31:0] instruction_q, instruction_d;
  logic        pred_result_q, pred_result_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        mem_send_q, mem_send_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  // Cache and predictor storage
  logic [IC_N-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [IC_N];
  logic [31:0]      data_q [IC_N];
  logic [1:0]       bht_q  [BHT_N];

  logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0]        pc_tag, fill_tag;
  logic [BHT_IDX_W-1:0]    bht_idx, upd_idx;
  logic                    hit, stall, bht_taken, fill_we;
  logic [31:0]             word, npc;
  logic                    npc_pred;
  logic                    unused_upd_bits;

  // 2-bit saturating counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'd1;
    else if (!taken && c != 2'b00) r = c - 2'd1;
    return r;
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  assign pc_idx    = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag    = pc_q[ADDR_W-1:ICACHE_IDX_W+2];
  assign fill_idx  = mem_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag  = mem_addr_q[ADDR_W-1:ICACHE_IDX_W+2];
  assign bht_idx   = pc_q[BHT_IDX_W+1:2];
  assign upd_idx   = upd_pc[BHT_IDX_W+1:2];
  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign word      = data_q[pc_idx];
  assign bht_taken = bht_q[bht_idx][1];
  assign stall     = RS_full || SLB_full || ROB_full;

  // Upper/lower upd_pc bits do not participate in BHT indexing
  assign unused_upd_bits = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

  assign ID_send     = id_send_q;
  assign instruction = instruction_q;
  assign pred_result = pred_result_q;
  assign inst_pc     = inst_pc_q;
  assign mem_send    = mem_send_q;
  assign mem_addr    = mem_addr_q;

  // Next-PC prediction for the word currently at pc
  always_comb begin
    npc      = pc_q + 32'd4;
    npc_pred = 1'b0;
    if (word[6:0] == OP_JAL) begin
      npc      = pc_q + j_imm(word);
      npc_pred = 1'b1;
    end else if (word[6:0] == OP_BRANCH && bht_taken) begin
      npc      = pc_q + b_imm(word);
      npc_pred = 1'b1;
    end
  end

  // Issue decision, miss FSM next state and redirect handling
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_send_d     = 1'b0;
    instruction_d = instruction_q;
    pred_result_d = pred_result_q;
    inst_pc_d     = inst_pc_q;
    mem_send_d    = mem_send_q;
    mem_addr_d    = mem_addr_q;
    fill_we       = 1'b0;
    if (jump_rst) begin
      // Abandon any in-flight miss; a same-cycle mem_valid is dropped
      pc_d       = jump_pc;
      mem_send_d = 1'b0;
      mem_addr_d = 32'd0;
      state_d    = IDLE;
    end else begin
      if (hit && !stall) begin
        id_send_d     = 1'b1;
        instruction_d = word;
        inst_pc_d     = pc_q;
        pred_result_d = npc_pred;
        pc_d          = npc;
      end
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_d    = MISS;
            mem_send_d = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        MISS: begin
          if (mem_valid) begin
            fill_we    = 1'b1;
            mem_send_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= 32'd0;
      id_send_q     <= 1'b0;
      instruction_q <= 32'd0;
      pred_result_q <= 1'b0;
      inst_pc_q     <= 32'd0;
      mem_send_q    <= 1'b0;
      mem_addr_q    <= 32'd0;
    end else if (rdy) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_send_q     <= id_send_d;
      instruction_q <= instruction_d;
      pred_result_q <= pred_result_d;
      inst_pc_q     <= inst_pc_d;
      mem_send_q    <= mem_send_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  // Cache valid bits; cleared by reset so a cold cache always misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && fill_we) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Cache tag and data arrays, written on refill
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_val;
    end
  end

  // BHT counters: weakly not-taken after reset, trained by commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy && upd_valid) begin
      bht_q[upd_idx] <= ctr_next(bht_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: tb/tb_if_bht_fetch.sv
// Bench for if_bht_fetch: memory responder model, directed fetch
// sequences and a scoreboard monitor comparing every ID_send.
module tb_if_bht_fetch;

  logic        clk, rst, rdy, jump_rst;
  logic [31:0] jump_pc;
  logic        RS_full, SLB_full, ROB_full;
  logic        ID_send, pred_result;
  logic [31:0] instruction, inst_pc;
  logic        mem_valid, mem_send;
  logic [31:0] mem_val, mem_addr;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc;

  if_bht_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst), .jump_pc(jump_pc),
    .RS_full(RS_full), .SLB_full(SLB_full), .ROB_full(ROB_full),
    .ID_send(ID_send), .instruction(instruction), .pred_result(pred_result),
    .inst_pc(inst_pc), .mem_valid(mem_valid), .mem_val(mem_val),
    .mem_send(mem_send), .mem_addr(mem_addr), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] JAL = 32'h0200_006F;  // jal x0,+0x20

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] img [int unsigned];
  int          checks = 0;
  int          errors = 0;
  logic        mem_en = 1'b1;
  int          mem_lat = 3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] img_rd(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return NOP;
  endfunction

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic pr);
    exp_t e;
    e.pc = p; e.ins = i; e.pred = pr;
    sb.push_back(e);
  endtask

  // Memory responder: answers a held request after mem_lat cycles
  initial begin
    int cnt;
    cnt = 0;
    mem_valid = 1'b0;
    mem_val = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        mem_valid = 1'b0;
        if (mem_send) begin
          cnt++;
          if (cnt >= mem_lat) begin
            mem_valid = 1'b1;
            mem_val = img_rd(mem_addr);
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every ID_send pops one expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ID_send === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send actual=inst_pc %h expected=no send", inst_pc);
        end else begin
          e = sb.pop_front();
          chk("send_pc", inst_pc, e.pc);
          chk("send_instr", instruction, e.ins);
          chk("send_pred", {31'd0, pred_result}, {31'd0, e.pred});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic pulse_jump(input logic [31:0] t);
    @(negedge clk);
    jump_pc = t;
    jump_rst = 1'b1;
    @(negedge clk);
    jump_rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_seq(input logic [31:0] start);
    pulse_jump(start);
    RS_full = 1'b0;
    wait_drain(60);
    RS_full = 1'b1;
  endtask

  task automatic wait_mem_send(input string nm, input int budget, input logic [31:0] exp_addr);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (mem_send) break;
    end
    chk({nm, "_req"}, {31'd0, mem_send}, 32'd1);
    chk({nm, "_addr"}, mem_addr, exp_addr);
  endtask

  task automatic bht_upd(input logic [31:0] p, input logic t);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = p;
    upd_taken = t;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    int hi;
    logic bad;
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; jump_pc = 32'd0;
    RS_full = 1'b0; SLB_full = 1'b0; ROB_full = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    img[32'h40]  = BEQ;
    img[32'h100] = JAL;
    img[32'h300] = 32'hCAFE_0013;
    img[32'h400] = 32'hBEEF_0013;

    // Reset state
    #12;
    chk("rst_id_send", {31'd0, ID_send}, 32'd0);
    chk("rst_mem_send", {31'd0, mem_send}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pred", {31'd0, pred_result}, 32'd0);

    // Cold start: miss at 0, three-cycle memory, then send, then ask for 4
    push(32'h0, NOP, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hi = 0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (mem_send) begin
        hi++;
        if (mem_addr != 32'h0) bad = 1'b1;
      end else if (hi > 0) begin
        break;
      end
    end
    chk("cold_req_cycles", hi, 32'd3);
    chk("cold_req_addr_stable", {31'd0, bad}, 32'd0);
    wait_drain(20);
    RS_full = 1'b1;
    wait_mem_send("cold_next", 6, 32'h4);

    // rdy=0 freezes BHT: two taken updates are lost
    @(negedge clk);
    rdy = 1'b0;
    bht_upd(32'h40, 1'b1);
    bht_upd(32'h40, 1'b1);
    @(negedge clk);
    rdy = 1'b1;
    push(32'h40, BEQ, 1'b0);
    run_seq(32'h40);

    // Train to 3; second update coincides with a redirect
    bht_upd(32'h40, 1'b1);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    jump_rst = 1'b1; jump_pc = 32'h80;
    @(negedge clk);
    upd_valid = 1'b0; jump_rst = 1'b0;
    push(32'h40, BEQ, 1'b1);
    push(32'h38, NOP, 1'b0);
    run_seq(32'h40);

    // Saturate at 3 then one not-taken: counter 2, still taken
    bht_upd(32'h40, 1'b1);
    bht_upd(32'h40, 1'b0);
    push(32'h40, BEQ, 1'b1);
    push(32'h38, NOP, 1'b0);
    run_seq(32'h40);

    // Saturate at 0, then two taken: counter 2, taken
    bht_upd(32'h40, 1'b0);
    bht_upd(32'h40, 1'b0);
    bht_upd(32'h40, 1'b0);
    bht_upd(32'h40, 1'b1);
    bht_upd(32'h40, 1'b1);
    push(32'h40, BEQ, 1'b1);
    push(32'h38, NOP, 1'b0);
    run_seq(32'h40);

    // Back down to 0: not taken, falls through to 0x44
    bht_upd(32'h40, 1'b0);
    bht_upd(32'h40, 1'b0);
    push(32'h40, BEQ, 1'b0);
    push(32'h44, NOP, 1'b0);
    run_seq(32'h40);

    // JAL redirect independent of BHT
    push(32'h100, JAL, 1'b1);
    push(32'h120, NOP, 1'b0);
    run_seq(32'h100);

    // Redirect in the same cycle as mem_valid: fill dropped
    @(negedge clk);
    mem_en = 1'b0;
    mem_valid = 1'b0;
    pulse_jump(32'h300);
    wait_mem_send("redir_first", 6, 32'h300);
    @(negedge clk);
    mem_valid = 1'b1; mem_val = 32'hDEAD_BEEF;
    jump_rst = 1'b1; jump_pc = 32'h200;
    @(negedge clk);
    mem_valid = 1'b0; jump_rst = 1'b0;
    #1;
    chk("redir_mem_send", {31'd0, mem_send}, 32'd0);
    chk("redir_mem_addr", mem_addr, 32'd0);
    wait_mem_send("redir_new", 4, 32'h200);
    mem_en = 1'b1;
    push(32'h200, NOP, 1'b0);
    run_seq(32'h200);
    push(32'h300, 32'hCAFE_0013, 1'b0);
    run_seq(32'h300);

    // Stall in a hit stream: warm lines first, then replay with ROB_full
    for (int a = 0; a < 4; a++) push(32'h500 + 32'(a * 4), NOP, 1'b0);
    run_seq(32'h500);
    for (int a = 0; a < 4; a++) push(32'h500 + 32'(a * 4), NOP, 1'b0);
    pulse_jump(32'h500);
    RS_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() <= 2) break;
    end
    ROB_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_id_send", {31'd0, ID_send}, 32'd0);
      chk("stall_inst_pc", inst_pc, 32'h504);
    end
    ROB_full = 1'b0;
    wait_drain(20);
    RS_full = 1'b1;

    // Conflict: 0x400 evicts 0x0
    pulse_jump(32'h400);
    wait_mem_send("conf_400", 4, 32'h400);
    push(32'h400, 32'hBEEF_0013, 1'b0);
    run_seq(32'h400);
    pulse_jump(32'h0);
    wait_mem_send("conf_0", 4, 32'h0);
    push(32'h0, NOP, 1'b0);
    run_seq(32'h0);

    // Async reset mid-miss clears outputs without a clock edge
    @(negedge clk);
    mem_en = 1'b0;
    mem_valid = 1'b0;
    pulse_jump(32'h600);
    wait_mem_send("arst_pre", 4, 32'h600);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_mem_send", {31'd0, mem_send}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b1;
    push(32'h0, NOP, 1'b0);
    RS_full = 1'b0;
    wait_mem_send("arst_cold", 4, 32'h0);
    wait_drain(30);
    RS_full = 1'b1;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
